// File: rtl/lambert_shade_if.sv
// Operand/result handshake bundle for lambert_shade, plus the shared status type.
// Vector components are packed as [2]=z, [1]=y, [0]=x, each a signed Q word.
package lambert_shade_pkg;
  typedef enum logic {
    SHADE_IDLE = 1'b0,
    SHADE_BUSY = 1'b1
  } shade_state_t;
endpackage

interface lambert_shade_if #(
  parameter int WIDTH = 32
);
  import lambert_shade_pkg::*;

  logic                  valid_in;
  logic [2:0][WIDTH-1:0] normal;
  logic [2:0][WIDTH-1:0] light_dir;
  logic [WIDTH-1:0]      intensity;
  logic                  in_ready;
  logic [WIDTH-1:0]      result;
  logic                  backface;
  logic                  valid_out;
  shade_state_t          shade_state;

  modport master (
    output valid_in, normal, light_dir, intensity,
    input  in_ready, result, backface, valid_out, shade_state
  );

  modport slave (
    input  valid_in, normal, light_dir, intensity,
    output in_ready, result, backface, valid_out, shade_state
  );
endinterface

// File: rtl/lambert_shade.sv
// Lambert diffuse shading: clamp(dot(N,L),0,1)*intensity in signed Q fixed point,
// computed over five cycles with one shared multiplier.
module lambert_shade
  import lambert_shade_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int Q_BITS = 16
) (
  input logic            clk,
  input logic            reset,
  lambert_shade_if.slave bus
);

  localparam int ACC_W  = WIDTH + 2;
  localparam int PROD_W = 2 * WIDTH;

  localparam logic signed [ACC_W-1:0]  ONE_ACC = ACC_W'(1) << Q_BITS;
  localparam logic [WIDTH-1:0]         MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] MAX_P   = PROD_W'(MAX_W);

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    MUL_Z,
    SCALE
  } state_t;

  state_t state_q, state_d;

  logic [2:0][WIDTH-1:0]    n_q;
  logic [2:0][WIDTH-1:0]    l_q;
  logic signed [WIDTH-1:0]  i_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [WIDTH-1:0]         result_q;
  logic                     backface_q;
  logic                     valid_q;

  logic signed [WIDTH-1:0]  mul_a;
  logic signed [WIDTH-1:0]  mul_b;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] shifted;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  clamp;
  logic signed [WIDTH-1:0]  int_pos;
  logic [WIDTH-1:0]         sat_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_in) state_d = MUL_X;
      MUL_X:   state_d = MUL_Y;
      MUL_Y:   state_d = MUL_Z;
      MUL_Z:   state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clamp = acc_q;
    if (acc_q < 0) begin
      clamp = '0;
    end else if (acc_q > ONE_ACC) begin
      clamp = ONE_ACC;
    end
  end

  assign int_pos = i_q[WIDTH-1] ? '0 : i_q;

  // The one multiplier walks x, y, z products, then the clamped-dot * intensity scale.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      MUL_X:   begin mul_a = $signed(n_q[0]); mul_b = $signed(l_q[0]); end
      MUL_Y:   begin mul_a = $signed(n_q[1]); mul_b = $signed(l_q[1]); end
      MUL_Z:   begin mul_a = $signed(n_q[2]); mul_b = $signed(l_q[2]); end
      SCALE:   begin mul_a = $signed(clamp[WIDTH-1:0]); mul_b = int_pos; end
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  assign product    = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign shifted    = product >>> Q_BITS;
  assign term       = shifted[ACC_W-1:0];
  assign sat_result = (shifted > MAX_P) ? MAX_W : shifted[WIDTH-1:0];

  // Operands are captured only on acceptance so upstream may change them while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q        <= '0;
      l_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      backface_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            n_q   <= bus.normal;
            l_q   <= bus.light_dir;
            i_q   <= $signed(bus.intensity);
            acc_q <= '0;
          end
        end
        MUL_X, MUL_Y, MUL_Z: begin
          acc_q <= acc_q + term;
        end
        SCALE: begin
          backface_q <= (acc_q < 0);
          result_q   <= sat_result;
          valid_q    <= 1'b1;
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.result      = result_q;
  assign bus.backface    = backface_q;
  assign bus.valid_out   = valid_q;
  assign bus.shade_state = (state_q == IDLE) ? SHADE_IDLE : SHADE_BUSY;

endmodule

// File: tb/tb_lambert_shade.sv
// Scoreboard bench for lambert_shade: directed vectors push expectations,
// a negedge monitor pops and compares on every valid_out pulse.
module tb_lambert_shade;
  import lambert_shade_pkg::*;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] MONE = 32'hFFFF_0000;

  typedef struct {
    logic [31:0] res;
    logic        bf;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  lambert_shade_if #(.WIDTH(32)) bus ();

  lambert_shade #(
    .WIDTH (32),
    .Q_BITS(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Every valid_out pulse must match the oldest outstanding expectation and its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_valid_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_output("result", 64'(bus.result), 64'(e.res));
        check_output("backface", 64'(bus.backface), 64'(e.bf));
        check_output("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] nz,
                                input logic [31:0] lx, input logic [31:0] ly, input logic [31:0] lz,
                                input logic [31:0] inten, input logic [31:0] er, input logic eb,
                                input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.normal    = {nz, ny, nx};
    bus.light_dir = {lz, ly, lx};
    bus.intensity = inten;
    bus.valid_in  = 1'b1;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check_output("accept_timeout", 64'd0, 64'd1);
      bus.valid_in = 1'b0;
      return;
    end
    sb.push_back('{er, eb, cyc + 5});
    @(posedge clk);
    #1;
    if (!hold) bus.valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_output(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.normal    = '0;
    bus.light_dir = '0;
    bus.intensity = '0;
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_output("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check_output("rst_result", 64'(bus.result), 64'd0);
    check_output("rst_backface", 64'(bus.backface), 64'd0);
    check_output("rst_state", 64'(bus.shade_state), 64'(SHADE_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    apply_stimulus(0, 0, ONE, 0, 0, ONE, ONE, ONE, 1'b0, 0);
    check_output("busy_state", 64'(bus.shade_state), 64'(SHADE_BUSY));
    apply_stimulus(0, 0, ONE, 0, 0, MONE, ONE, 32'h0, 1'b1, 0);
    apply_stimulus(32'h8000, 32'h8000, 0, ONE, 0, 0, 32'h0002_0000, ONE, 1'b0, 0);
    apply_stimulus(ONE, ONE, ONE, ONE, ONE, ONE, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 0);
    apply_stimulus(ONE, ONE, ONE, ONE, ONE, ONE, MONE, 32'h0, 1'b0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, ONE, 32'h0, 1'b0, 0);
    apply_stimulus(32'h1, 0, 0, 32'hFFFF_FFFF, 0, 0, ONE, 32'h0, 1'b1, 0);
    apply_stimulus(32'h4000, 0, 0, 32'h4000, 0, 0, 32'h0003_0000, 32'h3000, 1'b0, 0);
    drain("drain_basic");

    // Extra valid_in pulses with different data while busy must not disturb the op.
    apply_stimulus(32'h8000, 32'h8000, 0, ONE, 0, 0, 32'h0002_0000, ONE, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.valid_in  = 1'b1;
      bus.normal    = {MONE, MONE, MONE};
      bus.light_dir = {ONE, ONE, ONE};
      bus.intensity = 32'h0005_0000;
      check_output("busy_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    drain("drain_ignored");

    apply_stimulus(0, 0, ONE, 0, 0, ONE, ONE, ONE, 1'b0, 1);
    apply_stimulus(32'h4000, 0, 0, 32'h4000, 0, 0, 32'h0003_0000, 32'h3000, 1'b0, 0);
    drain("drain_b2b");

    // Abort an op in MUL_Y; its pulse must never appear.
    apply_stimulus(0, 0, ONE, 0, 0, ONE, ONE, ONE, 1'b0, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    check_output("abort_result", 64'(bus.result), 64'd0);
    check_output("abort_valid_out", 64'(bus.valid_out), 64'd0);
    check_output("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check_output("abort_state", 64'(bus.shade_state), 64'(SHADE_IDLE));
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    apply_stimulus(32'h8000, 32'h8000, 0, ONE, 0, 0, 32'h0002_0000, ONE, 1'b0, 0);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
